// File: rtl/ovl_pkg.sv
// Shared OVL constants: severity levels, property types, coverage levels
// and bit positions inside the fire vector.
package ovl_pkg;

  localparam int OVL_FATAL   = 0;
  localparam int OVL_ERROR   = 1;
  localparam int OVL_WARNING = 2;
  localparam int OVL_INFO    = 3;

  localparam int OVL_ASSERT = 0;
  localparam int OVL_ASSUME = 1;
  localparam int OVL_IGNORE = 2;

  localparam int OVL_COVER_NONE = 0;
  localparam int OVL_COVER_ON   = 1;

  localparam int OVL_FIRE_VIOL  = 0;
  localparam int OVL_FIRE_XZ    = 1;
  localparam int OVL_FIRE_COVER = 2;

endpackage

// File: rtl/ovl_no_overflow_checker.sv
// Flags a monitored value that leaves (min, max] right after sitting at max.
// fire[0] violation, fire[1] X/Z sample, fire[2] reached-max coverage.
module ovl_no_overflow_checker
  import ovl_pkg::*;
#(
  parameter int              severity_level = OVL_ERROR,
  parameter int              width          = 1,
  parameter longint unsigned min            = 64'd0,
  parameter longint unsigned max            = (64'd1 << width) - 64'd1,
  parameter int              property_type  = OVL_ASSERT,
  parameter string           msg            = "VIOLATION",
  parameter int              coverage_level = OVL_COVER_NONE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [width-1:0] test_expr,
  output logic [2:0]       fire
);

  // Compare in 33 bits so full-range thresholds never fold into constants.
  localparam logic [32:0] MIN_X = 33'(min);
  localparam logic [32:0] MAX_X = 33'(max);

  logic [width-1:0] prev_r;
  logic             prev_valid_r;
  logic [2:0]       fire_r;

  logic [32:0] te_x_s;
  logic [32:0] prev_x_s;
  logic        xz_s;
  logic        viol_s;
  logic        cov_s;
  logic [2:0]  fire_nxt_s;

  // Detect the overflow, unknown-sample and reached-max conditions.
  always_comb begin
    te_x_s   = 33'(test_expr);
    prev_x_s = 33'(prev_r);
    xz_s     = 1'b0;
`ifndef SYNTHESIS
    xz_s     = $isunknown(test_expr);
`endif
    viol_s   = prev_valid_r && enable && !xz_s && (prev_x_s == MAX_X) &&
               ((te_x_s <= MIN_X) || (te_x_s > MAX_X));
    cov_s    = (coverage_level == OVL_COVER_ON) && prev_valid_r && !xz_s &&
               (te_x_s == MAX_X) && (prev_x_s != MAX_X);
    fire_nxt_s = 3'b000;
    if (property_type == OVL_IGNORE) begin
      fire_nxt_s = 3'b000;
    end else begin
      fire_nxt_s[OVL_FIRE_VIOL]  = viol_s;
      fire_nxt_s[OVL_FIRE_XZ]    = enable && xz_s;
      fire_nxt_s[OVL_FIRE_COVER] = cov_s;
    end
  end

  // Previous-sample history and registered fire pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_r       <= '0;
      prev_valid_r <= 1'b0;
      fire_r       <= 3'b000;
    end else begin
      fire_r <= fire_nxt_s;
      if (xz_s) begin
        prev_valid_r <= 1'b0;
      end else begin
        prev_r       <= test_expr;
        prev_valid_r <= 1'b1;
      end
    end
  end

  assign fire = fire_r;

`ifndef SYNTHESIS
  task automatic report_violation();
    string tag;
    case (severity_level)
      OVL_FATAL:   tag = "OVL_FATAL";
      OVL_ERROR:   tag = "OVL_ERROR";
      OVL_WARNING: tag = "OVL_WARNING";
      OVL_INFO:    tag = "OVL_INFO";
      default:     tag = "OVL_ERROR";
    endcase
    $display("%s : %s : %m : time %0t", tag, msg, $time);
    if (severity_level == OVL_FATAL) begin
      $finish;
    end
  endtask

  // One message per violating edge unless the property is ignored.
  always @(posedge clock) begin
    if (!reset && viol_s && (property_type != OVL_IGNORE)) begin
      report_violation();
    end
  end
`endif

endmodule

// File: tb/tb_ovl_no_overflow_checker.sv
// Random and directed stimulus for three checker configurations, compared
// every cycle against a rule-level reference model.
module tb_ovl_no_overflow_checker;
  import ovl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       te1;
  logic [3:0] te4;
  logic [2:0] fa, fb, fc;

  int n_total = 0;
  int n_bad   = 0;

  int unsigned pa, pb;
  bit          va, vb;
  logic [2:0]  ea, eb, ec;

  always #5 clk = ~clk;

  ovl_no_overflow_checker #(
    .severity_level(OVL_INFO), .width(1), .msg("overflow seen")
  ) u_a (
    .clock(clk), .reset(rst), .enable(en), .test_expr(te1), .fire(fa)
  );

  ovl_no_overflow_checker #(
    .severity_level(OVL_INFO), .width(4), .min(64'd2), .max(64'd9),
    .coverage_level(OVL_COVER_ON), .msg("overflow seen")
  ) u_b (
    .clock(clk), .reset(rst), .enable(en), .test_expr(te4), .fire(fb)
  );

  ovl_no_overflow_checker #(
    .severity_level(OVL_INFO), .width(1), .property_type(OVL_IGNORE),
    .coverage_level(OVL_COVER_ON)
  ) u_c (
    .clock(clk), .reset(rst), .enable(en), .test_expr(te1), .fire(fc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected fire vector for one edge, from the checker's rules.
  function automatic logic [2:0] ref_fire(input int unsigned te, input bit xz, input bit e,
                                          input int unsigned prev, input bit pv,
                                          input int unsigned mn, input int unsigned mx,
                                          input bit cov_on, input bit ign);
    logic [2:0] r;
    r = 3'b000;
    if (ign) return r;
    if (pv && !xz && e && prev == mx && (te <= mn || te > mx)) r[0] = 1'b1;
    if (e && xz) r[1] = 1'b1;
    if (cov_on && pv && !xz && te == mx && prev != mx) r[2] = 1'b1;
    return r;
  endfunction

  task automatic step(input logic t1, input logic [3:0] t4, input logic e);
    bit x1, x4;
    @(negedge clk);
    te1 = t1;
    te4 = t4;
    en  = e;
    @(posedge clk);
    x1 = $isunknown(te1);
    x4 = $isunknown(te4);
    ea = ref_fire(32'(te1), x1, en, pa, va, 0, 1, 1'b0, 1'b0);
    eb = ref_fire(32'(te4), x4, en, pb, vb, 2, 9, 1'b1, 1'b0);
    ec = ref_fire(32'(te1), x1, en, pa, va, 0, 1, 1'b1, 1'b1);
    if (x1) va = 1'b0; else begin pa = 32'(te1); va = 1'b1; end
    if (x4) vb = 1'b0; else begin pb = 32'(te4); vb = 1'b1; end
    #1;
    chk("fire_a", 32'(fa), 32'(ea));
    chk("fire_b", 32'(fb), 32'(eb));
    chk("fire_c", 32'(fc), 32'(ec));
  endtask

  // Asynchronous reset pulse starting mid-cycle; fire must clear at once.
  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_fire_a", 32'(fa), 32'd0);
    chk("rst_fire_b", 32'(fb), 32'd0);
    chk("rst_fire_c", 32'(fc), 32'd0);
    pa = 0; va = 1'b0;
    pb = 0; vb = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    te1 = 1'b0;
    te4 = 4'd0;
    pa = 0; va = 1'b0;
    pb = 0; vb = 1'b0;
    #1;
    chk("reset_a", 32'(fa), 32'd0);
    chk("reset_b", 32'(fb), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Held at max for ten edges, then drop: exactly one pulse.
    repeat (10) step(1'b1, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    chk("a_drop_fires", 32'(fa[0]), 32'd1);
    step(1'b0, 4'd0, 1'b1);
    chk("a_single_pulse", 32'(fa[0]), 32'd0);

    // Enable low masks the drop; enable high catches it.
    step(1'b1, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b0);
    chk("a_en_off", 32'(fa[0]), 32'd0);
    step(1'b1, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    chk("a_en_on", 32'(fa[0]), 32'd1);

    // Bounded range min=2, max=9.
    step(1'b0, 4'd9, 1'b1);
    step(1'b0, 4'd5, 1'b1);
    chk("b_9_to_5", 32'(fb[0]), 32'd0);
    step(1'b0, 4'd9, 1'b1);
    chk("b_cov_5_to_9", 32'(fb[2]), 32'd1);
    step(1'b0, 4'd9, 1'b1);
    chk("b_9_to_9", 32'(fb), 32'd0);
    step(1'b0, 4'd2, 1'b1);
    chk("b_9_to_2", 32'(fb[0]), 32'd1);
    step(1'b0, 4'd9, 1'b1);
    step(1'b0, 4'd12, 1'b1);
    chk("b_9_to_12", 32'(fb[0]), 32'd1);
    step(1'b0, 4'd8, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    chk("b_8_to_0", 32'(fb[0]), 32'd0);
    step(1'b0, 4'd3, 1'b1);
    step(1'b0, 4'd9, 1'b1);
    chk("b_cov_3_to_9", 32'(fb[2]), 32'd1);
    step(1'b0, 4'd9, 1'b1);
    chk("b_cov_hold", 32'(fb[2]), 32'd0);
    step(1'b0, 4'bx01x, 1'b1);
    step(1'b0, 4'd5, 1'b1);

    // Reset between max and the drop: nothing fires after release.
    step(1'b1, 4'd9, 1'b1);
    pulse_reset();
    step(1'b0, 4'd0, 1'b1);
    chk("a_post_reset", 32'(fa), 32'd0);
    chk("b_post_reset", 32'(fb), 32'd0);

    // Reset landing on a live pulse clears it.
    step(1'b1, 4'd9, 1'b1);
    step(1'b0, 4'd12, 1'b1);
    chk("b_pulse_live", 32'(fb[0]), 32'd1);
    pulse_reset();

    for (int i = 0; i < 400; i++) begin
      logic       r1;
      logic [3:0] r4;
      logic       re;
      r1 = 1'($urandom_range(0, 1));
      r4 = ($urandom_range(0, 2) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
      re = ($urandom_range(0, 4) != 0);
      step(r1, r4, re);
      if ($urandom_range(0, 49) == 0) pulse_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ovl_no_overflow_checker.md
OVL_NO_OVERFLOW_CHECKER -- requirements
Module: ovl_no_overflow_checker

Interface
REQ-001 Parameters: severity_level, default 1, 0=fatal, 1=error, 2=warning, 3=info; fixes message tag only.
REQ-002 Parameters: width, default 1, test_expr width, range 1..32.
REQ-003 Parameters: min, default 0, lower bound; max, default (2**width)-1, overflow threshold; min < max required.
REQ-004 Parameters: property_type, default 0, 0=assert, 1=assume, 2=ignore (no fire, no message); msg, default "VIOLATION", message text.
REQ-005 Parameters: coverage_level, default 0, 0=off, 1=enable coverage pulse.
REQ-006 Port: clock  in  1  sole clock; all sampling on its rising edge.
REQ-007 Port: reset  in  1  asynchronous, active-high reset.
REQ-008 Port: enable  in  1  check qualifier; 0 suppresses violation detection.
REQ-009 Port: test_expr  in  width  monitored unsigned value.
REQ-010 Port: fire  out  3  [0]=assertion violation, [1]=X/Z on test_expr, [2]=coverage event.

Function
REQ-011 Every rising clock edge registers test_expr into prev and sets prev_valid=1, independent of enable.
REQ-012 Violation at edge k: prev_valid=1, prev==max, enable=1, and current test_expr <= min or > max; value compares unsigned, full width.
REQ-013 A value held at max across edges (max->max) is legal; only a move out of (min, max] after max is a violation.
REQ-014 fire[0] registered: high during the cycle after the edge that detects a violation, for exactly one cycle per violating edge; consecutive violations keep it high.
REQ-015 Violation with property_type 0 or 1 prints one line per violating edge: severity tag, msg, instance path, simulation time; fatal severity calls $finish after the message.
REQ-016 fire[1]: registered one-cycle pulse when enable=1 and test_expr contains X or Z at an edge (simulation only; constant 0 under SYNTHESIS); the X sample is not stored into prev (prev_valid cleared).
REQ-017 fire[2], coverage_level=1: one-cycle registered pulse at each edge where prev_valid=1 and test_expr==max while prev!=max (reached max); otherwise constant 0.
REQ-018 property_type 2 forces fire to 3'b000 and suppresses messages.
REQ-019 width=1, min=0, max=1: sequence 1,1,...,1,0 fires exactly once, on the 1->0 edge.

Reset
REQ-020 reset=1 asynchronously clears prev_valid, prev=0, fire=3'b000 regardless of clock.
REQ-021 First rising edge after reset release only loads prev; no violation or coverage is possible before the second edge.
REQ-022 Reset asserted mid-pulse clears fire immediately; no pending violation survives reset.

Structure
REQ-023 Shared package ovl_pkg holds severity constants (OVL_FATAL..OVL_INFO), property_type constants (OVL_ASSERT, OVL_ASSUME, OVL_IGNORE), coverage-level constants and fire bit-index constants.
REQ-024 Single module, no sub-module; message formatting in a local task inside the module.
REQ-025 Bench clock from the existing free-running clock generator at 100 MHz (10 ns period), instantiated beside the checker.

Verification
REQ-026 width=1 defaults, reset pulse, test_expr=1 held 10 edges then 0 -> fire[0]=1 for exactly one cycle after the 1->0 edge, one error message.
REQ-027 width=4, min=2, max=9: 9->5 no fire; 9->9 no fire; 9->2 fire; 9->12 fire; 8->0 no fire.
REQ-028 width=1: enable=0 on the 1->0 edge -> fire[0] stays 0; repeat with enable=1 -> fires.
REQ-029 reset asserted between sample of max and following 0 -> no fire after release; first post-reset edge never fires.
REQ-030 coverage_level=1, width=4, max=9: 3->9 -> fire[2] pulse one cycle; 9->9 -> no pulse; test_expr=4'bx01x with enable=1 -> fire[1] pulse.
REQ-031 property_type=2 with REQ-026 stimulus -> fire stays 3'b000, no message.
